// File: rtl/tri_raster_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tri_raster_ctrl_pkg                                          |
// | Description : Shared graphics types for the triangle rasterizer: vertex/    |
// |               triangle structs, sequencer state, pixel coordinate, and the |
// |               edge function used for point-in-triangle tests.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package tri_raster_ctrl_pkg;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } int_point;

    typedef struct packed {
        int_point a;
        int_point b;
        int_point c;
    } int_triangle;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } rast_state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } pix_coord_t;

    // Cross product of (b-a) and (p-a); 68 bits holds any 33b x 33b product difference.
    function automatic logic signed [67:0] edge_fn(input int_point a, input int_point b,
                                                   input int_point p);
        logic signed [67:0] dx_ab;
        logic signed [67:0] dy_ab;
        logic signed [67:0] dx_ap;
        logic signed [67:0] dy_ap;
        dx_ab = 68'(b.x) - 68'(a.x);
        dy_ab = 68'(b.y) - 68'(a.y);
        dx_ap = 68'(p.x) - 68'(a.x);
        dy_ap = 68'(p.y) - 68'(a.y);
        return (dx_ab * dy_ap) - (dy_ab * dx_ap);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_raster_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tri_raster_ctrl_if                                           |
// | Description : Triangle-in / pixel-out stream bundle of the rasterizer.     |
// |               Stats outputs exist only when RASTER_STATS_EN is defined.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface tri_raster_ctrl_if #(
    parameter int COORD_W = 16
);
    import tri_raster_ctrl_pkg::*;

    logic               tri_valid;
    logic               tri_ready;
    int_triangle        tri_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               busy;
    logic               done;
`ifdef RASTER_STATS_EN
    logic [31:0]        stat_tested;
    logic [31:0]        stat_covered;
`endif

    modport slave (
        input  tri_valid, tri_in, pix_ready,
        output tri_ready, pix_valid, pix_x, pix_y, busy, done
`ifdef RASTER_STATS_EN
        , output stat_tested, stat_covered
`endif
    );

    modport master (
        output tri_valid, tri_in, pix_ready,
        input  tri_ready, pix_valid, pix_x, pix_y, busy, done
`ifdef RASTER_STATS_EN
        , input stat_tested, stat_covered
`endif
    );
endinterface
`default_nettype wire

// File: rtl/tri_raster_ctrl_point_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tri_point_tester                                             |
// | Description : Combinational inclusion test: point is covered when the      |
// |               triangle is counter-clockwise and all three edges are >= 0.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tri_point_tester
    import tri_raster_ctrl_pkg::*;
(
    input  int_triangle tri_in,
    input  int_point    pt,
    output logic        point_in_tri
);
    logic signed [67:0] w_area;
    logic signed [67:0] w_e_ab;
    logic signed [67:0] w_e_bc;
    logic signed [67:0] w_e_ca;

    always_comb begin
        w_area       = edge_fn(tri_in.a, tri_in.b, tri_in.c);
        w_e_ab       = edge_fn(tri_in.a, tri_in.b, pt);
        w_e_bc       = edge_fn(tri_in.b, tri_in.c, pt);
        w_e_ca       = edge_fn(tri_in.c, tri_in.a, pt);
        point_in_tri = (w_area > 0) && !w_e_ab[67] && !w_e_bc[67] && !w_e_ca[67];
    end
endmodule
`default_nettype wire

// File: rtl/tri_raster_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tri_raster_ctrl                                              |
// | Description : Scans the screen-clipped bounding box of one triangle in     |
// |               row-major order and streams covered pixels. Optional         |
// |               tested/covered counters via RASTER_STATS_EN.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tri_raster_ctrl
    import tri_raster_ctrl_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 16
) (
    input  wire               clk,
    input  wire               rst,
    tri_raster_ctrl_if.slave  bus
);
    rast_state_t        state_q, state_d;
    int_triangle        tri_q, tri_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               pix_valid_q, pix_valid_d;
    logic               tri_ready_q, tri_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef RASTER_STATS_EN
    logic [31:0]        stat_tested_q, stat_tested_d;
    logic [31:0]        stat_covered_q, stat_covered_d;
`endif

    logic signed [31:0] w_xmin_raw, w_xmax_raw, w_ymin_raw, w_ymax_raw;
    logic               w_empty;
    logic               w_adv;
    logic               w_in_tri;
    int_point           w_point;

    function automatic logic signed [31:0] min3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
        logic signed [31:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [31:0] max3(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c);
        logic signed [31:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [31:0] v,
                                                       input int hi);
        if (v < 0)       return '0;
        else if (v > hi) return COORD_W'(hi);
        else             return COORD_W'(v);
    endfunction

    assign w_point.x = 32'(cur_x_q);
    assign w_point.y = 32'(cur_y_q);

    tri_point_tester u_tester (
        .tri_in       (tri_q),
        .pt           (w_point),
        .point_in_tri (w_in_tri)
    );

    always_comb begin
        state_d     = state_q;
        tri_d       = tri_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymax_d      = ymax_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        done_d      = 1'b0;
`ifdef RASTER_STATS_EN
        stat_tested_d  = stat_tested_q;
        stat_covered_d = stat_covered_q;
`endif
        w_xmin_raw = min3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        w_xmax_raw = max3(tri_q.a.x, tri_q.b.x, tri_q.c.x);
        w_ymin_raw = min3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
        w_ymax_raw = max3(tri_q.a.y, tri_q.b.y, tri_q.c.y);
        // Box lies wholly off-screen on some axis: nothing to scan.
        w_empty = (w_xmax_raw < 0) || (w_xmin_raw > SCREEN_W - 1) ||
                  (w_ymax_raw < 0) || (w_ymin_raw > SCREEN_H - 1);
        w_adv   = !pix_valid_q || bus.pix_ready;

        case (state_q)
            IDLE: begin
                if (bus.tri_valid && tri_ready_q) begin
                    tri_d   = bus.tri_in;
                    state_d = SETUP;
`ifdef RASTER_STATS_EN
                    stat_tested_d  = '0;
                    stat_covered_d = '0;
`endif
                end
            end
            SETUP: begin
                xmin_d  = clamp_coord(w_xmin_raw, SCREEN_W - 1);
                xmax_d  = clamp_coord(w_xmax_raw, SCREEN_W - 1);
                ymax_d  = clamp_coord(w_ymax_raw, SCREEN_H - 1);
                cur_x_d = clamp_coord(w_xmin_raw, SCREEN_W - 1);
                cur_y_d = clamp_coord(w_ymin_raw, SCREEN_H - 1);
                state_d = w_empty ? DRAIN : SCAN;
            end
            SCAN: begin
                if (w_adv) begin
                    pix_valid_d = w_in_tri;
                    if (w_in_tri) begin
                        pix_x_d = cur_x_q;
                        pix_y_d = cur_y_q;
                    end
`ifdef RASTER_STATS_EN
                    stat_tested_d = stat_tested_q + 32'd1;
                    if (w_in_tri) stat_covered_d = stat_covered_q + 32'd1;
`endif
                    if (cur_x_q == xmax_q) begin
                        cur_x_d = xmin_q;
                        if (cur_y_q == ymax_q) state_d = DRAIN;
                        else                   cur_y_d = cur_y_q + COORD_W'(1);
                    end else begin
                        cur_x_d = cur_x_q + COORD_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (w_adv) begin
                    pix_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tri_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tri_q       <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymax_q      <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            tri_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RASTER_STATS_EN
            stat_tested_q  <= '0;
            stat_covered_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tri_q       <= tri_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymax_q      <= ymax_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            tri_ready_q <= tri_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef RASTER_STATS_EN
            stat_tested_q  <= stat_tested_d;
            stat_covered_q <= stat_covered_d;
`endif
        end
    end

    assign bus.tri_ready = tri_ready_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef RASTER_STATS_EN
    assign bus.stat_tested  = stat_tested_q;
    assign bus.stat_covered = stat_covered_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_tri_raster_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tri_raster_ctrl                                           |
// | Description : Directed bench for tri_raster_ctrl (stats checked when       |
// |               RASTER_STATS_EN is defined).                                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_tri_raster_ctrl;
    import tri_raster_ctrl_pkg::*;

    localparam int c_W  = 640;
    localparam int c_H  = 480;
    localparam int c_CW = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_lat;
    logic [15:0] lfsr;
    pix_coord_t  got[$];
    pix_coord_t  exp_q[$];
    int_triangle t1, t2, t3, t4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tri_raster_ctrl_if #(.COORD_W(c_CW)) bus ();

    tri_raster_ctrl #(.SCREEN_W(c_W), .SCREEN_H(c_H), .COORD_W(c_CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int_triangle mk(input int ax, input int ay, input int bx,
                                       input int by, input int cx, input int cy);
        int_triangle t;
        t.a.x = ax; t.a.y = ay;
        t.b.x = bx; t.b.y = by;
        t.c.x = cx; t.c.y = cy;
        return t;
    endfunction

    // Handshake one triangle, then collect accepted pixels until done or budget.
    task automatic run_tri(input int_triangle t, input bit bp, input int budget);
        bit          stall;
        logic [15:0] hx, hy;
        int          k;
        stall    = 1'b0;
        hx       = '0;
        hy       = '0;
        done_lat = -1;
        got.delete();
        @(negedge clk);
        chk("tri_ready_idle", bus.tri_ready, 1);
        bus.tri_valid = 1'b1;
        bus.tri_in    = t;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("tri_ready_while_busy", bus.tri_ready, 0);
        k = 1;
        while (k <= budget && done_lat < 0) begin
            if (bus.done) begin
                done_lat = k;
            end else begin
                if (stall) begin
                    chk("stall_hold_valid", bus.pix_valid, 1);
                    chk("stall_hold_x", bus.pix_x, hx);
                    chk("stall_hold_y", bus.pix_y, hy);
                end
                if (bp) begin
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    bus.pix_ready = lfsr[0];
                end else begin
                    bus.pix_ready = 1'b1;
                end
                stall = bus.pix_valid && !bus.pix_ready;
                hx    = bus.pix_x;
                hy    = bus.pix_y;
                if (bus.pix_valid && bus.pix_ready) got.push_back('{x: bus.pix_x, y: bus.pix_y});
                @(negedge clk);
                k++;
            end
        end
        chk("done_timed_out", (done_lat < 0), 0);
        chk("busy_at_done", bus.busy, 0);
        chk("pix_valid_at_done", bus.pix_valid, 0);
        @(negedge clk);
        chk("done_single_cycle", bus.done, 0);
        bus.pix_ready = 1'b1;
    endtask

    task automatic cmp_pix(input string tag);
        chk({tag, "_pix_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_pix%0d_x", tag, i), got[i].x, exp_q[i].x);
            chk($sformatf("%s_pix%0d_y", tag, i), got[i].y, exp_q[i].y);
        end
    endtask

    initial begin
        t1 = mk(0, 0, 4, 0, 0, 4);
        t2 = mk(0, 0, 0, 4, 4, 0);
        t3 = mk(-10, -10, -2, -10, -10, -2);
        t4 = mk(630, 0, 700, 0, 630, 20);
        lfsr          = 16'hACE1;
        rst           = 1'b1;
        bus.tri_valid = 1'b0;
        bus.tri_in    = '0;
        bus.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tri_ready", bus.tri_ready, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_x", bus.pix_x, 0);
        chk("rst_pix_y", bus.pix_y, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tri_ready", bus.tri_ready, 1);

        // Test 1: CCW right triangle, covered set is x+y<=4 in a 5x5 box.
        exp_q.delete();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) exp_q.push_back('{x: 16'(x), y: 16'(y)});
        run_tri(t1, 1'b0, 100);
        chk("t1_count", got.size(), 15);
        cmp_pix("t1");
        chk("t1_done_latency", done_lat, 28);
`ifdef RASTER_STATS_EN
        chk("t1_stat_tested", bus.stat_tested, 25);
        chk("t1_stat_covered", bus.stat_covered, 15);
`endif

        // Test 2: clockwise winding scans the full box but covers nothing.
        run_tri(t2, 1'b0, 100);
        chk("t2_count", got.size(), 0);
        chk("t2_done_latency", done_lat, 28);

        // Test 3: box entirely left/above the screen.
        run_tri(t3, 1'b0, 20);
        chk("t3_count", got.size(), 0);
        chk("t3_done_latency", done_lat, 3);

        // Test 4: right-edge clip to x<=639; 10x21 box, coverage 7y+2x<=1400.
        exp_q.delete();
        for (int y = 0; y <= 20; y++)
            for (int x = 630; x <= 639; x++)
                if (7 * y + 2 * x <= 1400) exp_q.push_back('{x: 16'(x), y: 16'(y)});
        run_tri(t4, 1'b0, 400);
        chk("t4_count", got.size(), 193);
        cmp_pix("t4");
        chk("t4_done_latency", done_lat, 213);

        // Test 5: test 1 under pseudo-random backpressure.
        exp_q.delete();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                if (x + y <= 4) exp_q.push_back('{x: 16'(x), y: 16'(y)});
        run_tri(t1, 1'b1, 500);
        cmp_pix("t5");

        // Test 6: reset mid-scan, then a clean rerun.
        @(negedge clk);
        bus.tri_valid = 1'b1;
        bus.tri_in    = t1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_pix_valid", bus.pix_valid, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_done", bus.done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_done", bus.done, 0);
            chk("t6_idle_ready", bus.tri_ready, 1);
            chk("t6_idle_busy", bus.busy, 0);
        end
        run_tri(t1, 1'b0, 100);
        cmp_pix("t6");
        chk("t6_done_latency", done_lat, 28);
`ifdef RASTER_STATS_EN
        chk("t6_stat_tested", bus.stat_tested, 25);
        chk("t6_stat_covered", bus.stat_covered, 15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
